// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, reset PC
// and the word-alignment helper used by the PC register.
package ifetch_unit_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Default program counter after reset (word-aligned)
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Low address bits of a word-aligned address
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

    // True when the two low address bits describe a word boundary
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/ifetch_unit_pc_reg.sv
// Program counter register with synchronous reset, write enable and an
// alignment check. A write of a non-word-aligned value is dropped and
// reported through the misalign strobe instead.
module ifetch_unit_pc_reg
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] pc,
    output logic        misalign
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        aligned;

    assign aligned  = is_word_aligned(wr_data[1:0]);
    assign misalign = wr_en & ~aligned;
    assign pc       = pc_reg;

    // Next PC: load only aligned values when write is enabled
    always_comb begin
        pc_next = pc_reg;
        if (wr_en && aligned) begin
            pc_next = wr_data;
        end
    end

    // PC state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one word fetch per request
// over a ready handshake and captures the returned word into the IR.
// The PC is frozen while a request is outstanding so the fetch address
// never changes under the memory.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        pc_wr,
    input  logic        fetch_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] npc_t,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        err
);

    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic [31:0] ir_reg;
    logic [31:0] ir_next;
    logic        ir_valid_reg;
    logic        ir_valid_next;
    logic        err_reg;
    logic        err_next;
    logic        pc_wr_en;
    logic        pc_misalign;
    logic        in_wait;

    assign in_wait  = (state_reg == ST_WAIT);

    // PC writes are only honoured while no fetch is outstanding
    assign pc_wr_en = pc_wr & ~in_wait;

    ifetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) pc_reg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (pc_wr_en),
        .wr_data  (npc),
        .pc       (pc),
        .misalign (pc_misalign)
    );

    assign npc_t     = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = in_wait;
    assign busy      = in_wait;
    assign ir        = ir_reg;
    assign ir_valid  = ir_valid_reg;
    assign err       = err_reg;

    // FSM transitions, IR capture and sticky error detection
    always_comb begin
        state_next    = state_reg;
        ir_next       = ir_reg;
        ir_valid_next = 1'b0;
        err_next      = err_reg;
        if (in_wait) begin
            if (imem_ready) begin
                ir_next       = imem_rdata;
                ir_valid_next = 1'b1;
                state_next    = ST_IDLE;
            end
            if (pc_wr) begin
                err_next = 1'b1;
            end
        end else begin
            if (fetch_req) begin
                state_next = ST_WAIT;
            end
            if (pc_misalign) begin
                err_next = 1'b1;
            end
        end
    end

    // Control and data state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ir_reg       <= 32'h0;
            ir_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. Each issued fetch pushes its expected
// address and word onto a scoreboard queue; a negedge monitor checks the
// address when memory accepts and the IR when ir_valid pulses.
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        pc_wr;
    logic        fetch_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] npc_t;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        err;

    fetch_exp_t  exp_q[$];
    int          check_cnt;
    int          error_cnt;
    int          valid_cnt;
    int          push_cnt;

    ifetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc_wr      (pc_wr),
        .fetch_req  (fetch_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .npc_t      (npc_t),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        fetch_exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        push_cnt++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pc_wr      = 1'b0;
        fetch_req  = 1'b0;
        imem_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (exp_q.size() == 0) begin
                check("accept_without_expect", 32'(exp_q.size()), 32'd1);
            end else begin
                check("accept_addr", imem_addr, exp_q[0].addr);
                $display("accept addr=%08h rdata=%08h", imem_addr, imem_rdata);
            end
        end
        if (ir_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_ir_valid", {31'h0, ir_valid}, 32'h0);
            end else begin
                fetch_exp_t e;
                e = exp_q.pop_front();
                check("ir_data", ir, e.data);
                $display("ir_valid ir=%08h exp=%08h", ir, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        check_cnt  = 0;
        error_cnt  = 0;
        valid_cnt  = 0;
        push_cnt   = 0;
        npc        = 32'h0;
        imem_rdata = 32'h0;
        do_reset();

        // Reset state
        smp();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_npc_t", npc_t, 32'h0000_3004);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // Minimum-latency fetch
        cyc();
        fetch_req = 1'b1;
        push_exp(32'h0000_3000, 32'h2008_0005);
        smp();
        check("t1_req_idle", {31'h0, imem_req}, 32'h0);
        cyc();
        fetch_req  = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        smp();
        check("t1_req", {31'h0, imem_req}, 32'h1);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_addr", imem_addr, 32'h0000_3000);
        cyc();
        imem_ready = 1'b0;
        smp();
        check("t1_ir_valid", {31'h0, ir_valid}, 32'h1);
        check("t1_ir", ir, 32'h2008_0005);
        check("t1_npc_t", npc_t, 32'h0000_3004);
        check("t1_busy_after", {31'h0, busy}, 32'h0);
        cyc();
        smp();
        check("t1_ir_valid_drop", {31'h0, ir_valid}, 32'h0);

        // PC write and fetch in the same idle cycle
        cyc();
        npc       = 32'h0000_3040;
        pc_wr     = 1'b1;
        fetch_req = 1'b1;
        push_exp(32'h0000_3040, 32'hA5A5_0001);
        cyc();
        pc_wr     = 1'b0;
        fetch_req = 1'b0;
        smp();
        check("t2_addr", imem_addr, 32'h0000_3040);
        check("t2_npc_t", npc_t, 32'h0000_3044);
        cyc();
        imem_ready = 1'b1;
        imem_rdata = 32'hA5A5_0001;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("t2_ir_valid", {31'h0, ir_valid}, 32'h1);

        // Memory stall of 4 cycles with an extra request mid-stall
        cyc();
        fetch_req = 1'b1;
        push_exp(32'h0000_3040, 32'h1234_5678);
        cyc();
        for (int i = 0; i < 5; i++) begin
            fetch_req  = (i == 2);
            imem_ready = (i == 4);
            imem_rdata = 32'h1234_5678;
            smp();
            check($sformatf("t3_req_%0d", i), {31'h0, imem_req}, 32'h1);
            check($sformatf("t3_addr_%0d", i), imem_addr, 32'h0000_3040);
            check($sformatf("t3_nv_%0d", i), {31'h0, ir_valid}, 32'h0);
            cyc();
        end
        fetch_req  = 1'b0;
        imem_ready = 1'b0;
        smp();
        check("t3_ir_valid", {31'h0, ir_valid}, 32'h1);
        check("t3_req_done", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            check($sformatf("t3_no_queue_%0d", i), {31'h0, imem_req}, 32'h0);
        end

        // Misaligned PC write
        do_reset();
        cyc();
        npc   = 32'h0000_3042;
        pc_wr = 1'b1;
        cyc();
        pc_wr = 1'b0;
        smp();
        check("t4_pc", pc, 32'h0000_3000);
        check("t4_err", {31'h0, err}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
        end
        check("t4_err_sticky", {31'h0, err}, 32'h1);

        // Aligned write to the top word: PC+4 wraps
        cyc();
        npc   = 32'hFFFF_FFFC;
        pc_wr = 1'b1;
        cyc();
        pc_wr = 1'b0;
        smp();
        check("t4_pc_top", pc, 32'hFFFF_FFFC);
        check("t4_npc_wrap", npc_t, 32'h0000_0000);
        check("t4_err_still", {31'h0, err}, 32'h1);

        // PC write during WAIT is rejected
        do_reset();
        smp();
        check("t5_err_clr", {31'h0, err}, 32'h0);
        check("t5_pc_rst", pc, 32'h0000_3000);
        cyc();
        fetch_req = 1'b1;
        push_exp(32'h0000_3000, 32'hCAFE_F00D);
        cyc();
        fetch_req = 1'b0;
        npc       = 32'h0000_5000;
        pc_wr     = 1'b1;
        cyc();
        pc_wr = 1'b0;
        smp();
        check("t5_pc", pc, 32'h0000_3000);
        check("t5_err", {31'h0, err}, 32'h1);
        check("t5_req", {31'h0, imem_req}, 32'h1);
        cyc();
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        cyc();
        imem_ready = 1'b0;
        smp();
        check("t5_ir_valid", {31'h0, ir_valid}, 32'h1);

        // Reset during WAIT abandons the fetch
        cyc();
        fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        rst       = 1'b1;
        cyc();
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        smp();
        check("t6_req", {31'h0, imem_req}, 32'h0);
        check("t6_ir", ir, 32'h0);
        check("t6_pc", pc, 32'h0000_3000);
        check("t6_err", {31'h0, err}, 32'h0);
        cyc();
        imem_ready = 1'b0;
        smp();
        check("t6_no_valid", {31'h0, ir_valid}, 32'h0);
        check("t6_ir_hold", ir, 32'h0);
        cyc();
        smp();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("valid_count", 32'(valid_cnt), 32'(push_cnt));

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the multi-cycle CPU, sitting directly downstream of the next-PC logic. Holds the program counter, loads the next-PC value when the controller commits an instruction, issues one word-fetch to instruction memory per request over a ready-handshake, and latches the returned word into the instruction register. It also produces `npc_t` (PC+4), which feeds back into next-PC selection.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset; must be word-aligned.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `npc`  in  32  next PC from next-PC logic.
- `pc_wr`  in  1  controller commit: load `npc` into PC.
- `fetch_req`  in  1  controller request to fetch the instruction at the current PC.
- `imem_req`  out  1  memory request, held until accepted.
- `imem_addr`  out  32  fetch address; equals `pc` and is stable while `imem_req`=1.
- `imem_ready`  in  1  memory accept/data-valid strobe, sampled only while `imem_req`=1.
- `imem_rdata`  in  32  fetched word, valid when `imem_ready`=1.
- `pc`  out  32  current program counter.
- `npc_t`  out  32  `pc`+4, combinational from `pc`.
- `ir`  out  32  instruction register.
- `ir_valid`  out  1  one-cycle pulse: `ir` was just updated.
- `busy`  out  1  high while a fetch is outstanding.
- `err`  out  1  sticky error flag, cleared only by reset.

## Operation
- FSM with two states: IDLE, WAIT.
- IDLE: `imem_req`=0, `busy`=0. When `fetch_req`=1, go to WAIT.
- WAIT: `imem_req`=1, `busy`=1, `imem_addr`=`pc`. When `imem_ready`=1, set `ir`<=`imem_rdata`, `ir_valid`<=1 for the next cycle only, and go to IDLE. Without `imem_ready`, stay in WAIT indefinitely.
- PC update applies in IDLE only. When `pc_wr`=1 and `npc[1:0]`=0, set `pc`<=`npc`. When `pc_wr`=1 and `npc[1:0]`!=0, keep `pc` unchanged and set `err`<=1.
- `pc_wr`=1 in WAIT: ignored, `pc` unchanged, `err`<=1. The address must not change under an outstanding request.
- `fetch_req`=1 in WAIT: ignored. Requests are not queued and no error is raised.
- `pc_wr` and `fetch_req` in the same IDLE cycle: PC updates at that edge, and the fetch issued in WAIT uses the new PC.
- `npc_t` = `pc` + 32'd4, modulo 2^32. 32'hFFFF_FFFC yields 32'h0000_0000.
- Reset values: `pc`=`RESET_PC`, `npc_t`=`RESET_PC`+4, `ir`=32'h0, `ir_valid`=0, `imem_req`=0, `busy`=0, `err`=0, state=IDLE.
- Reset during WAIT abandons the fetch: `imem_req` is low from the cycle after the reset edge, and a late `imem_ready` is ignored.

## Timing
- `fetch_req` sampled at edge k leads to `imem_req`=1 in cycle k+1.
- `imem_ready` sampled at edge m leads to `ir` updated and `ir_valid`=1 in cycle m+1.
- Minimum fetch latency: `ir_valid` two cycles after `fetch_req`, when memory is ready in its first request cycle.
- Back-to-back fetches: a new `fetch_req` is accepted in the `ir_valid` cycle (IDLE). Peak throughput is one fetch per 2 cycles.
- All outputs are registered except `npc_t` (combinational from `pc`) and `imem_addr` (wired to `pc`).

## Structure
- Shared header/package holds:
  - FSM state encodings (IDLE=1'b0, WAIT=1'b1);
  - the default `RESET_PC` constant;
  - the word-alignment mask 2'b00.
- One natural sub-module: `pc_reg`. It holds the 32-bit PC with a synchronous reset value, a write enable, and the alignment check that produces the misalign strobe.
- FSM, IR and `err` live in `ifetch_unit`.

## Test plan
- Reset, then `fetch_req` for one cycle, `imem_ready`=1 with `imem_rdata`=32'h2008_0005 in the first WAIT cycle:
  - `imem_addr`=32'h0000_3000;
  - `ir`=32'h2008_0005 and `ir_valid` pulses in cycle 3;
  - `npc_t`=32'h0000_3004.
- `pc_wr` with `npc`=32'h0000_3040 and `fetch_req` in the same cycle: `imem_addr`=32'h0000_3040 in the WAIT cycle.
- Memory stall: `imem_ready` held low 4 cycles, then pulsed.
  - `imem_req` and `imem_addr` stay stable for 5 cycles;
  - exactly one `ir_valid` pulse;
  - an extra `fetch_req` mid-stall is ignored.
- `pc_wr` with `npc`=32'h0000_3042: `pc` stays 32'h0000_3000, `err`=1 and stays 1 until `rst`.
- `pc_wr` with `npc`=32'h0000_5000 during WAIT: `pc` unchanged, `err`=1, the fetch completes at the old address.
- `rst` asserted during WAIT, then `imem_ready`=1 one cycle later:
  - `imem_req`=0;
  - `ir`=32'h0;
  - no `ir_valid`;
  - `pc`=32'h0000_3000.
